// File: rtl/a_matrix_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : a_matrix_sequencer_if
//  Description : Handshake and register-file bus of the matrix-A sequencer.
//                master = sequencer side, slave = sampler/consumer/regfile side.
//  Revision    : 1.0  initial release
// ============================================================================
interface a_matrix_sequencer_if;
    logic        start_fill;
    logic        start_read;
    logic        transpose;
    logic        coef_valid;
    logic [15:0] coef_in;
    logic        coef_ready;
    logic        out_ready;
    logic        out_valid;
    logic        out_last;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] data_in;
    logic [2:0]  outer_loop;
    logic [2:0]  inner_loop;
    logic [7:0]  i;
    logic        loop_end;
    logic        busy;
    logic        done;

    modport master (
        input  start_fill, start_read, transpose, coef_valid, coef_in, out_ready,
        output coef_ready, out_valid, out_last, write_enable, read_enable,
               data_in, outer_loop, inner_loop, i, loop_end, busy, done
    );

    modport slave (
        output start_fill, start_read, transpose, coef_valid, coef_in, out_ready,
        input  coef_ready, out_valid, out_last, write_enable, read_enable,
               data_in, outer_loop, inner_loop, i, loop_end, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/a_matrix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : a_matrix_sequencer
//  Description : Sequences a full fill of the Kyber matrix-A register file
//                from the sampler stream, and full read sweeps (A or A^T).
//                Index order: i fastest, then column, then row.
//  Revision    : 1.0  initial release
// ============================================================================
module a_matrix_sequencer #(
    parameter int KYBER_SECURITY = 2,
    parameter int N_COEFF        = 256
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    a_matrix_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_last_rc = 3'(KYBER_SECURITY - 1);
    localparam logic [7:0] c_last_i  = 8'(N_COEFF - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [7:0] r_idx;
    logic       r_transpose;
    logic       r_out_valid;
    logic       r_out_last;

    logic       w_coef_ready;
    logic       w_write_en;
    logic       w_read_en;
    logic       w_done;
    logic       w_latch_tr;
    logic       w_at_last;
    logic       w_access;
    logic       w_swap;

    assign w_at_last = (r_row == c_last_rc) && (r_col == c_last_rc) && (r_idx == c_last_i);
    assign w_access  = w_write_en | w_read_en;
    // Only a read sweep may swap row/column; a stale transpose must not affect a fill.
    assign w_swap    = r_transpose && (r_state == ST_READ);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state strobes; fill has priority over read in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_coef_ready = 1'b0;
        w_write_en   = 1'b0;
        w_read_en    = 1'b0;
        w_done       = 1'b0;
        w_latch_tr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_fill) begin
                    w_next_state = ST_FILL;
                end else if (bus.start_read) begin
                    w_next_state = ST_READ;
                    w_latch_tr   = 1'b1;
                end
            end
            ST_FILL: begin
                w_coef_ready = 1'b1;
                w_write_en   = bus.coef_valid;
                if (bus.coef_valid && w_at_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_READ: begin
                w_read_en = bus.out_ready;
                if (bus.out_ready && w_at_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Coefficient/column/row counters: advance on each access, cleared in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= 3'd0;
            r_col <= 3'd0;
            r_idx <= 8'd0;
        end else if (r_state == ST_DONE) begin
            r_row <= 3'd0;
            r_col <= 3'd0;
            r_idx <= 8'd0;
        end else if (w_access) begin
            if (r_idx == c_last_i) begin
                r_idx <= 8'd0;
                if (r_col == c_last_rc) begin
                    r_col <= 3'd0;
                    r_row <= (r_row == c_last_rc) ? 3'd0 : r_row + 3'd1;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end else begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Transpose is captured only when a read sweep actually starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_transpose <= 1'b0;
        end else if (w_latch_tr) begin
            r_transpose <= bus.transpose;
        end
    end

    // Register-file read latency is one cycle; valid/last follow the request by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= w_read_en;
            r_out_last  <= w_read_en & w_at_last;
        end
    end

    assign bus.coef_ready   = w_coef_ready;
    assign bus.write_enable = w_write_en;
    assign bus.read_enable  = w_read_en;
    assign bus.data_in      = bus.coef_in;
    assign bus.outer_loop   = w_swap ? r_col : r_row;
    assign bus.inner_loop   = w_swap ? r_row : r_col;
    assign bus.i            = r_idx;
    assign bus.loop_end     = w_access & w_at_last;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.done         = w_done;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_last     = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_a_matrix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a_matrix_sequencer
//  Description : Directed bench for a_matrix_sequencer (K=2, N_COEFF=256)
//                with a behavioural register file attached to its bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_a_matrix_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    a_matrix_sequencer_if bus ();

    a_matrix_sequencer #(
        .KYBER_SECURITY(2),
        .N_COEFF       (256)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural register file: write on write_enable, 1-cycle read.
    logic [15:0] rf_mem [0:16383];
    logic [15:0] rf_dout;
    always @(posedge clk) begin
        if (bus.write_enable) rf_mem[{bus.outer_loop, bus.inner_loop, bus.i}] <= bus.data_in;
        if (bus.read_enable)  rf_dout <= rf_mem[{bus.outer_loop, bus.inner_loop, bus.i}];
    end

    // Access number k -> {row, col, i} in sweep order.
    function automatic logic [13:0] exp_idx(input int k);
        return {3'(k / 512), 3'((k / 256) % 2), 8'(k % 256)};
    endfunction

    // Indices driven for read number k, swapped when transposed.
    function automatic logic [13:0] exp_rd(input int k, input bit tr);
        if (tr) return {3'((k / 256) % 2), 3'(k / 512), 8'(k % 256)};
        return exp_idx(k);
    endfunction

    // Data returned for read k, given the fill stored value = linear fill index.
    function automatic logic [15:0] exp_data(input int k, input bit tr);
        if (tr) return 16'(((k / 256) % 2) * 512 + (k / 512) * 256 + (k % 256));
        return 16'(k);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_fill = 1'b0; bus.start_read = 1'b0; bus.transpose = 1'b0;
        bus.coef_valid = 1'b1; bus.coef_in = 16'hABCD; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.coef_ready, bus.write_enable, bus.read_enable,
             bus.out_valid, bus.out_last, bus.loop_end} !== 8'b0)
            $display("FAIL reset_flags got=%b want=00000000", {bus.busy, bus.done, bus.coef_ready,
                     bus.write_enable, bus.read_enable, bus.out_valid, bus.out_last, bus.loop_end});
        else n_pass++;
        n_total++;
        if ({bus.outer_loop, bus.inner_loop, bus.i} !== 14'd0)
            $display("FAIL reset_idx got=%h want=0", {bus.outer_loop, bus.inner_loop, bus.i});
        else n_pass++;
        n_total++;
        if (bus.data_in !== 16'hABCD)
            $display("FAIL reset_data_in got=%h want=abcd", bus.data_in);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; bus.coef_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.coef_ready} !== 2'b00)
            $display("FAIL reset_release_idle got=%b want=00", {bus.busy, bus.coef_ready});
        else n_pass++;
    endtask

    task automatic test_fill();
        @(negedge clk); bus.start_fill = 1'b1;
        @(negedge clk); bus.start_fill = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            bus.coef_valid = 1'b1; bus.coef_in = 16'(k);
            #1;
            n_total++;
            if ({bus.write_enable, bus.coef_ready, bus.busy, bus.read_enable} !== 4'b1110 ||
                {bus.outer_loop, bus.inner_loop, bus.i} !== exp_idx(k) ||
                bus.loop_end !== (k == 1023))
                $display("FAIL fill_write k=%0d got we/rdy/busy/re=%b idx=%h end=%b want 1110 idx=%h end=%b",
                         k, {bus.write_enable, bus.coef_ready, bus.busy, bus.read_enable},
                         {bus.outer_loop, bus.inner_loop, bus.i}, bus.loop_end, exp_idx(k), (k == 1023));
            else n_pass++;
            @(negedge clk);
        end
        bus.coef_valid = 1'b0;
        #1;
        n_total++;
        if ({bus.done, bus.busy, bus.write_enable, bus.out_valid} !== 4'b1100 ||
            {bus.outer_loop, bus.inner_loop, bus.i} !== 14'd0)
            $display("FAIL fill_done got done/busy/we/ov=%b idx=%h want 1100 idx=0",
                     {bus.done, bus.busy, bus.write_enable, bus.out_valid},
                     {bus.outer_loop, bus.inner_loop, bus.i});
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.done, bus.busy} !== 2'b00)
            $display("FAIL fill_idle got done/busy=%b want 00", {bus.done, bus.busy});
        else n_pass++;
    endtask

    task automatic test_read(input bit tr, input bit gappy);
        int  reads   = 0;
        int  cyc     = 0;
        bit  req;
        bit  prev_req = 1'b0;
        int  prev_k   = 0;
        @(negedge clk); bus.start_read = 1'b1; bus.transpose = tr; bus.out_ready = 1'b0;
        @(negedge clk); bus.start_read = 1'b0; bus.transpose = ~tr;
        while (reads < 1024 && cyc < 4000) begin
            req = gappy ? ((cyc % 3) != 2) : 1'b1;
            bus.out_ready = req;
            #1;
            n_total++;
            if (bus.read_enable !== req || bus.write_enable !== 1'b0 ||
                (req && ({bus.outer_loop, bus.inner_loop, bus.i} !== exp_rd(reads, tr))) ||
                bus.loop_end !== (req && reads == 1023))
                $display("FAIL read_req tr=%0d n=%0d got re/we=%b%b idx=%h end=%b want re=%b idx=%h",
                         tr, reads, bus.read_enable, bus.write_enable,
                         {bus.outer_loop, bus.inner_loop, bus.i}, bus.loop_end, req, exp_rd(reads, tr));
            else n_pass++;
            n_total++;
            if (bus.out_valid !== prev_req ||
                (prev_req && (rf_dout !== exp_data(prev_k, tr) || bus.out_last !== (prev_k == 1023))))
                $display("FAIL read_data tr=%0d n=%0d got ov=%b last=%b data=%h want ov=%b data=%h",
                         tr, prev_k, bus.out_valid, bus.out_last, rf_dout, prev_req, exp_data(prev_k, tr));
            else n_pass++;
            prev_req = req;
            prev_k   = reads;
            if (req) reads++;
            cyc++;
            @(negedge clk);
        end
        n_total++;
        if (reads < 1024) $display("FAIL read_timeout got reads=%0d want 1024", reads);
        else n_pass++;
        bus.out_ready = 1'b0;
        #1;
        n_total++;
        if ({bus.done, bus.out_valid, bus.out_last, bus.read_enable} !== 4'b1110 ||
            rf_dout !== exp_data(1023, tr))
            $display("FAIL read_done tr=%0d got done/ov/last/re=%b data=%h want 1110 data=%h",
                     tr, {bus.done, bus.out_valid, bus.out_last, bus.read_enable}, rf_dout,
                     exp_data(1023, tr));
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.out_valid, bus.out_last} !== 3'b000)
            $display("FAIL read_idle got busy/ov/last=%b want 000", {bus.busy, bus.out_valid, bus.out_last});
        else n_pass++;
    endtask

    task automatic test_stalled_fill();
        int k = 0;
        bit v;
        @(negedge clk); bus.start_fill = 1'b1;
        @(negedge clk); bus.start_fill = 1'b0;
        for (int t = 0; t < 2047; t++) begin
            v = ((t % 2) == 0);
            bus.coef_valid = v; bus.coef_in = 16'(k);
            #1;
            n_total++;
            if (bus.write_enable !== v || {bus.outer_loop, bus.inner_loop, bus.i} !== exp_idx(k) ||
                bus.loop_end !== (v && k == 1023) || bus.done !== 1'b0)
                $display("FAIL stall_fill t=%0d got we=%b idx=%h end=%b done=%b want we=%b idx=%h",
                         t, bus.write_enable, {bus.outer_loop, bus.inner_loop, bus.i},
                         bus.loop_end, bus.done, v, exp_idx(k));
            else n_pass++;
            if (v) k++;
            @(negedge clk);
        end
        bus.coef_valid = 1'b0;
        #1;
        n_total++;
        if (bus.done !== 1'b1) $display("FAIL stall_done got done=%b want 1", bus.done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_start_conflict();
        @(negedge clk);
        bus.start_fill = 1'b1; bus.start_read = 1'b1; bus.transpose = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start_fill = 1'b0; bus.start_read = 1'b0;
        #1;
        n_total++;
        if ({bus.coef_ready, bus.read_enable, bus.busy} !== 3'b101)
            $display("FAIL conflict_state got rdy/re/busy=%b want 101",
                     {bus.coef_ready, bus.read_enable, bus.busy});
        else n_pass++;
        for (int k = 0; k < 1024; k++) begin
            bus.coef_valid = 1'b1; bus.coef_in = 16'(k);
            bus.start_read = (k == 100);
            #1;
            n_total++;
            if (bus.write_enable !== 1'b1 || bus.read_enable !== 1'b0 ||
                {bus.outer_loop, bus.inner_loop, bus.i} !== exp_idx(k))
                $display("FAIL conflict_fill k=%0d got we/re=%b%b idx=%h want 10 idx=%h", k,
                         bus.write_enable, bus.read_enable, {bus.outer_loop, bus.inner_loop, bus.i}, exp_idx(k));
            else n_pass++;
            @(negedge clk);
        end
        bus.coef_valid = 1'b0; bus.start_read = 1'b0;
        #1;
        n_total++;
        if ({bus.done, bus.read_enable} !== 2'b10)
            $display("FAIL conflict_done got done/re=%b want 10", {bus.done, bus.read_enable});
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.read_enable, bus.out_valid} !== 3'b000)
            $display("FAIL conflict_idle got busy/re/ov=%b want 000", {bus.busy, bus.read_enable, bus.out_valid});
        else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk); bus.start_fill = 1'b1;
        @(negedge clk); bus.start_fill = 1'b0;
        for (int k = 0; k < 300; k++) begin
            bus.coef_valid = 1'b1; bus.coef_in = 16'(k);
            @(negedge clk);
        end
        bus.coef_in = 16'd300;
        #1;
        n_total++;
        if (bus.write_enable !== 1'b1 || {bus.outer_loop, bus.inner_loop, bus.i} !== exp_idx(300))
            $display("FAIL midrst_pre got we=%b idx=%h want 1 idx=%h", bus.write_enable,
                     {bus.outer_loop, bus.inner_loop, bus.i}, exp_idx(300));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.busy, bus.write_enable, bus.coef_ready, bus.loop_end, bus.done} !== 5'b0 ||
            {bus.outer_loop, bus.inner_loop, bus.i} !== 14'd0)
            $display("FAIL midrst_async got busy/we/rdy/end/done=%b idx=%h want 0",
                     {bus.busy, bus.write_enable, bus.coef_ready, bus.loop_end, bus.done},
                     {bus.outer_loop, bus.inner_loop, bus.i});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; bus.coef_valid = 1'b0;
        @(negedge clk); bus.start_fill = 1'b1;
        @(negedge clk); bus.start_fill = 1'b0; bus.coef_valid = 1'b1; bus.coef_in = 16'h1234;
        #1;
        n_total++;
        if (bus.write_enable !== 1'b1 || {bus.outer_loop, bus.inner_loop, bus.i} !== 14'd0)
            $display("FAIL midrst_restart got we=%b idx=%h want 1 idx=0", bus.write_enable,
                     {bus.outer_loop, bus.inner_loop, bus.i});
        else n_pass++;
        @(negedge clk); bus.coef_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read(1'b0, 1'b0);
        test_read(1'b1, 1'b1);
        test_stalled_fill();
        test_read(1'b0, 1'b1);
        test_start_conflict();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
